bingo_guess_ctrl: RTL and testbench

Parametrised per-board guess handler for the Bingo game, generalised to a SIDE×SIDE board. It accepts a local guess entered as BCD, or a remote guess received over the interboard link, depending on whose turn it is. It marks the matching cell in the circle map and rejects invalid or duplicate local entries with a pulse. It also maintains a registered count of completed lines, plus a bingo flag, for the game FSM.

---
 rtl/bingo_guess_ctrl_pkg.sv | 30 +++
 rtl/bingo_line_counter.sv | 53 +++++
 rtl/bingo_guess_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bingo_guess_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bingo_guess_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bingo_guess_ctrl_pkg
// Shared definitions for the Bingo guess handler:
//   - guess_state_t : FSM state encoding (IDLE, WAIT_IN, FIN)
//   - SEL_NUM / STATE_WIN : interboard message type codes
//   - bcd_to_bin    : two-digit BCD to 7-bit binary conversion
//   - bcd_digits_ok : both BCD digits are in 0..9
// -----------------------------------------------------------------------------
package bingo_guess_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        FIN     = 2'd2
    } guess_state_t;

    // Interboard message types shared with the link layer
    localparam logic [2:0] SEL_NUM   = 3'd1;
    localparam logic [2:0] STATE_WIN = 3'd4;

    // 10*tens + ones in 7 bits; only meaningful when both digits are <= 9
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
        return (7'(bcd[7:4]) * 7'd10) + 7'(bcd[3:0]);
    endfunction

    function automatic logic bcd_digits_ok(input logic [7:0] bcd);
        return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bingo_line_counter.sv
// -----------------------------------------------------------------------------
// bingo_line_counter
// Purely combinational count of fully marked lines on a SIDE x SIDE board.
// Cell p sits at row p / SIDE, column p % SIDE.
// Ports:
//   circle : CELLS-bit map of marked cells
//   count  : rows + columns + main diagonal + anti-diagonal that are complete
// -----------------------------------------------------------------------------
module bingo_line_counter #(
    parameter  int SIDE  = 5,
    localparam int CELLS = SIDE * SIDE,
    localparam int CNT_W = $clog2(2 * SIDE + 3)
) (
    input  logic [CELLS-1:0] circle,
    output logic [CNT_W-1:0] count
);

    logic [SIDE-1:0] row_full;
    logic [SIDE-1:0] col_full;
    logic [SIDE-1:0] diag_bits;
    logic [SIDE-1:0] anti_bits;

    genvar r, c, i;
    generate
        for (r = 0; r < SIDE; r++) begin : g_row
            assign row_full[r] = &circle[r*SIDE +: SIDE];
        end

        // Columns are strided, so gather each column into a vector first
        for (c = 0; c < SIDE; c++) begin : g_col
            logic [SIDE-1:0] col_bits;
            for (r = 0; r < SIDE; r++) begin : g_cell
                assign col_bits[r] = circle[r*SIDE + c];
            end
            assign col_full[c] = &col_bits;
        end

        for (i = 0; i < SIDE; i++) begin : g_diag
            assign diag_bits[i] = circle[i*SIDE + i];
            assign anti_bits[i] = circle[i*SIDE + (SIDE - 1 - i)];
        end
    endgenerate

    // Sum of all completed-line flags
    always_comb begin
        count = '0;
        for (int k = 0; k < SIDE; k++) begin
            count = count + CNT_W'(row_full[k]) + CNT_W'(col_full[k]);
        end
        count = count + CNT_W'(&diag_bits) + CNT_W'(&anti_bits);
    end

endmodule

// File: rtl/bingo_guess_ctrl.sv
// -----------------------------------------------------------------------------
// bingo_guess_ctrl
// Per-board guess handler. Each start_guess arms one round; the round accepts
// either a local BCD entry (local_turn=1) or a remote SEL_NUM message
// (local_turn=0), marks the matching cell and pulses guess_done. Bad local
// entries and out-of-range remote numbers pulse guess_reject. A remote
// STATE_WIN aborts the round. The completed-line count is registered.
// Ports:
//   clk, rst            : clock, async active-high reset
//   interboard_rst      : sync clear, same effect as rst
//   clear_guess         : sync clear of circle and line_count
//   start_guess         : arm one guess round
//   local_turn          : 1 = local entry, 0 = remote message
//   enter_pulse         : local confirm
//   cur_number_BCD      : local number, tens [7:4], ones [3:0]
//   interboard_en       : remote message valid
//   interboard_msg_type : SEL_NUM / STATE_WIN
//   interboard_number   : remote number
//   num_to_pos          : slice k-1 is the cell position of number k
//   guess_done          : pulse, guess accepted
//   guess_reject        : pulse, entry refused
//   guess_number        : last accepted number
//   circle              : marked cells
//   line_count          : completed lines
//   bingo               : line_count >= WIN_LINES
// -----------------------------------------------------------------------------
module bingo_guess_ctrl
    import bingo_guess_ctrl_pkg::*;
#(
    parameter int SIDE      = 5,
    parameter int WIN_LINES = 5,
    parameter int CELLS     = SIDE * SIDE,
    parameter int POS_W     = $clog2(CELLS),
    parameter int NUM_W     = $clog2(CELLS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           interboard_rst,
    input  logic                           clear_guess,
    input  logic                           start_guess,
    input  logic                           local_turn,
    input  logic                           enter_pulse,
    input  logic [7:0]                     cur_number_BCD,
    input  logic                           interboard_en,
    input  logic [2:0]                     interboard_msg_type,
    input  logic [NUM_W-1:0]               interboard_number,
    input  logic [CELLS*POS_W-1:0]         num_to_pos,
    output logic                           guess_done,
    output logic                           guess_reject,
    output logic [NUM_W-1:0]               guess_number,
    output logic [CELLS-1:0]               circle,
    output logic [$clog2(2*SIDE+3)-1:0]    line_count,
    output logic                           bingo
);

    localparam int               LC_W    = $clog2(2 * SIDE + 3);
    localparam logic [6:0]       CELLS_7 = 7'(CELLS);
    localparam logic [NUM_W-1:0] CELLS_N = NUM_W'(CELLS);
    localparam logic [LC_W-1:0]  WIN_T   = LC_W'(WIN_LINES);

    guess_state_t     state;
    logic [6:0]       local_num;
    logic             local_ok;
    logic             local_accept;
    logic             local_refuse;
    logic [POS_W-1:0] local_pos;
    logic [POS_W-1:0] remote_pos;
    logic             remote_range_ok;
    logic             remote_sel;
    logic             remote_win;
    logic [LC_W-1:0]  lines_now;

    bingo_line_counter #(
        .SIDE (SIDE)
    ) u_lines (
        .circle (circle),
        .count  (lines_now)
    );

    // Number-to-position lookup for both sources. A mux over all numbers keeps
    // the select in range even when the requested number is not.
    always_comb begin
        local_pos  = '0;
        remote_pos = '0;
        for (int k = 0; k < CELLS; k++) begin
            if (local_num == 7'(k + 1)) begin
                local_pos = num_to_pos[k*POS_W +: POS_W];
            end
            if (interboard_number == NUM_W'(k + 1)) begin
                remote_pos = num_to_pos[k*POS_W +: POS_W];
            end
        end
    end

    // Entry qualification; each side only listens while it owns the turn
    always_comb begin
        local_num       = bcd_to_bin(cur_number_BCD);
        local_ok        = bcd_digits_ok(cur_number_BCD)
                          && (local_num >= 7'd1) && (local_num <= CELLS_7)
                          && !circle[local_pos];
        local_accept    = local_turn && enter_pulse && local_ok;
        local_refuse    = local_turn && enter_pulse && !local_ok;
        remote_range_ok = (interboard_number >= NUM_W'(1))
                          && (interboard_number <= CELLS_N);
        remote_sel      = !local_turn && interboard_en
                          && (interboard_msg_type == SEL_NUM);
        remote_win      = !local_turn && interboard_en
                          && (interboard_msg_type == STATE_WIN);
    end

    // FSM, circle map, latched number, pulses and registered line count.
    // clear_guess wins over any decision in the same cycle and leaves the
    // state where it was.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            circle       <= '0;
            line_count   <= '0;
            guess_number <= '0;
            guess_done   <= 1'b0;
            guess_reject <= 1'b0;
        end else if (interboard_rst) begin
            state        <= IDLE;
            circle       <= '0;
            line_count   <= '0;
            guess_number <= '0;
            guess_done   <= 1'b0;
            guess_reject <= 1'b0;
        end else begin
            guess_done   <= 1'b0;
            guess_reject <= 1'b0;
            line_count   <= lines_now;
            if (clear_guess) begin
                circle     <= '0;
                line_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_guess) begin
                            state <= WAIT_IN;
                        end
                    end
                    WAIT_IN: begin
                        if (local_accept) begin
                            circle[local_pos] <= 1'b1;
                            guess_number      <= NUM_W'(local_num);
                            guess_done        <= 1'b1;
                            state             <= FIN;
                        end else if (local_refuse) begin
                            guess_reject <= 1'b1;
                        end else if (remote_sel) begin
                            if (remote_range_ok) begin
                                circle[remote_pos] <= 1'b1;
                                guess_number       <= interboard_number;
                                guess_done         <= 1'b1;
                                state              <= FIN;
                            end else begin
                                guess_reject <= 1'b1;
                            end
                        end else if (remote_win) begin
                            state <= IDLE;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bingo = (line_count >= WIN_T);

endmodule

// File: tb/tb_bingo_guess_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bingo_guess_ctrl
// Two instances (SIDE=5 and SIDE=9, WIN_LINES=2). Stimulus tasks update a
// board-level model and push expected responses into per-instance queues;
// monitor processes pop and compare whenever an instance pulses done/reject.
// -----------------------------------------------------------------------------
module tb_bingo_guess_ctrl;
    import bingo_guess_ctrl_pkg::*;

    localparam int WIN = 2;

    logic clk = 1'b0;
    logic rst;
    logic ib_rst;
    always #5 clk = ~clk;

    // SIDE=5 instance
    logic         start5, turn5, enter5, ib_en5, clear5;
    logic [7:0]   bcd5;
    logic [2:0]   type5;
    logic [4:0]   ib_num5;
    logic [124:0] map5;
    logic         done5, reject5, bingo5;
    logic [4:0]   gnum5;
    logic [24:0]  circle5;
    logic [3:0]   lc5;

    // SIDE=9 instance
    logic         start9, turn9, enter9, ib_en9, clear9;
    logic [7:0]   bcd9;
    logic [2:0]   type9;
    logic [6:0]   ib_num9;
    logic [566:0] map9;
    logic         done9, reject9, bingo9;
    logic [6:0]   gnum9;
    logic [80:0]  circle9;
    logic [4:0]   lc9;

    bingo_guess_ctrl #(.SIDE(5), .WIN_LINES(WIN)) dut5 (
        .clk(clk), .rst(rst), .interboard_rst(ib_rst), .clear_guess(clear5),
        .start_guess(start5), .local_turn(turn5), .enter_pulse(enter5),
        .cur_number_BCD(bcd5), .interboard_en(ib_en5),
        .interboard_msg_type(type5), .interboard_number(ib_num5),
        .num_to_pos(map5), .guess_done(done5), .guess_reject(reject5),
        .guess_number(gnum5), .circle(circle5), .line_count(lc5),
        .bingo(bingo5)
    );

    bingo_guess_ctrl #(.SIDE(9), .WIN_LINES(WIN)) dut9 (
        .clk(clk), .rst(rst), .interboard_rst(ib_rst), .clear_guess(clear9),
        .start_guess(start9), .local_turn(turn9), .enter_pulse(enter9),
        .cur_number_BCD(bcd9), .interboard_en(ib_en9),
        .interboard_msg_type(type9), .interboard_number(ib_num9),
        .num_to_pos(map9), .guess_done(done9), .guess_reject(reject9),
        .guess_number(gnum9), .circle(circle9), .line_count(lc9),
        .bingo(bingo9)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_done;
        int          number;
        logic [80:0] circ;
        int          prev_lc;
        int          lc;
    } exp_t;

    exp_t        sbq0[$];
    exp_t        sbq1[$];
    int          side_of[2] = '{5, 9};
    int          pos_map[2][82];
    int          num_of[2][81];
    logic [80:0] m_circle[2];
    bit          armed[2];
    bit          model_turn[2];
    int          last_num[2];
    int          tests = 0;
    int          fails = 0;

    task automatic checkOutput(input string name, input logic [80:0] act,
                               input logic [80:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Completed lines straight from the board rules
    function automatic int modelLines(input int idx);
        int  s = side_of[idx];
        int  n = 0;
        bit  full_d = 1'b1;
        bit  full_a = 1'b1;
        for (int r = 0; r < s; r++) begin
            bit full_r = 1'b1;
            bit full_c = 1'b1;
            for (int c = 0; c < s; c++) begin
                if (!m_circle[idx][r*s + c]) full_r = 1'b0;
                if (!m_circle[idx][c*s + r]) full_c = 1'b0;
            end
            n += int'(full_r) + int'(full_c);
            if (!m_circle[idx][r*s + r])           full_d = 1'b0;
            if (!m_circle[idx][r*s + (s - 1 - r)]) full_a = 1'b0;
        end
        return n + int'(full_d) + int'(full_a);
    endfunction

    function automatic logic [7:0] toBcd(input int n);
        logic [7:0] b;
        b[7:4] = 4'(n / 10);
        b[3:0] = 4'(n % 10);
        return b;
    endfunction

    task automatic pushExp(input int idx, input bit is_done, input int prev);
        exp_t e;
        e.is_done = is_done;
        e.number  = last_num[idx];
        e.circ    = m_circle[idx];
        e.prev_lc = prev;
        e.lc      = modelLines(idx);
        if (idx == 0) sbq0.push_back(e);
        else          sbq1.push_back(e);
    endtask

    task automatic modelLocal(input int idx, input logic [7:0] bcd);
        int tens  = int'(bcd[7:4]);
        int ones  = int'(bcd[3:0]);
        int n     = tens * 10 + ones;
        int cells = side_of[idx] * side_of[idx];
        int prev  = modelLines(idx);
        if (!model_turn[idx] || !armed[idx]) return;
        if (tens <= 9 && ones <= 9 && n >= 1 && n <= cells
            && !m_circle[idx][pos_map[idx][n]]) begin
            m_circle[idx][pos_map[idx][n]] = 1'b1;
            last_num[idx] = n;
            armed[idx]    = 1'b0;
            pushExp(idx, 1'b1, prev);
        end else begin
            pushExp(idx, 1'b0, prev);
        end
    endtask

    task automatic modelRemote(input int idx, input logic [2:0] mtype, input int n);
        int cells = side_of[idx] * side_of[idx];
        int prev  = modelLines(idx);
        if (model_turn[idx] || !armed[idx]) return;
        if (mtype == SEL_NUM) begin
            if (n >= 1 && n <= cells) begin
                m_circle[idx][pos_map[idx][n]] = 1'b1;
                last_num[idx] = n;
                armed[idx]    = 1'b0;
                pushExp(idx, 1'b1, prev);
            end else begin
                pushExp(idx, 1'b0, prev);
            end
        end else if (mtype == STATE_WIN) begin
            armed[idx] = 1'b0;
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            m_circle[i] = '0;
            armed[i]    = 1'b0;
            last_num[i] = 0;
        end
    endtask

    // ---------------- DUT accessors ----------------
    function automatic logic getDone(input int idx);
        return (idx == 0) ? done5 : done9;
    endfunction
    function automatic logic getReject(input int idx);
        return (idx == 0) ? reject5 : reject9;
    endfunction
    function automatic logic [6:0] getNumber(input int idx);
        return (idx == 0) ? 7'(gnum5) : gnum9;
    endfunction
    function automatic logic [80:0] getCircle(input int idx);
        return (idx == 0) ? 81'(circle5) : circle9;
    endfunction
    function automatic logic [4:0] getLc(input int idx);
        return (idx == 0) ? 5'(lc5) : lc9;
    endfunction
    function automatic logic getBingo(input int idx);
        return (idx == 0) ? bingo5 : bingo9;
    endfunction

    // Monitor: on each pulse pop the next expectation, check the pulse
    // cycle, then the line count one cycle later
    task automatic monitorLoop(input int idx);
        exp_t  e;
        bit    pend = 1'b0;
        int    pend_lc = 0;
        string tag = $sformatf("S%0d", side_of[idx]);
        forever begin
            @(negedge clk);
            if (pend) begin
                checkOutput({tag, " line_count"}, 81'(getLc(idx)), 81'(pend_lc));
                checkOutput({tag, " bingo"}, 81'(getBingo(idx)), 81'(pend_lc >= WIN));
                pend = 1'b0;
            end
            if (getDone(idx) || getReject(idx)) begin
                if ((idx == 0 && sbq0.size() == 0) || (idx == 1 && sbq1.size() == 0)) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL %s unexpected pulse: done=%0b reject=%0b, expected none",
                             tag, getDone(idx), getReject(idx));
                end else begin
                    e = (idx == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    checkOutput({tag, " guess_done"}, 81'(getDone(idx)), 81'(e.is_done));
                    checkOutput({tag, " guess_reject"}, 81'(getReject(idx)), 81'(!e.is_done));
                    checkOutput({tag, " guess_number"}, 81'(getNumber(idx)), 81'(e.number));
                    checkOutput({tag, " circle"}, getCircle(idx), e.circ);
                    checkOutput({tag, " line_count_t1"}, 81'(getLc(idx)), 81'(e.prev_lc));
                    checkOutput({tag, " bingo_t1"}, 81'(getBingo(idx)), 81'(e.prev_lc >= WIN));
                    pend    = 1'b1;
                    pend_lc = e.lc;
                end
            end
        end
    endtask

    initial monitorLoop(0);
    initial monitorLoop(1);

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one cycle of pulses on one instance, then release them
    task automatic applyStimulus(input int idx, input bit start, input bit enter,
                                 input bit en, input bit clr, input logic [7:0] bcd,
                                 input logic [2:0] mtype, input logic [6:0] num);
        @(negedge clk);
        if (idx == 0) begin
            start5 = start; enter5 = enter; ib_en5 = en; clear5 = clr;
            bcd5 = bcd; type5 = mtype; ib_num5 = num[4:0];
        end else begin
            start9 = start; enter9 = enter; ib_en9 = en; clear9 = clr;
            bcd9 = bcd; type9 = mtype; ib_num9 = num;
        end
        @(negedge clk);
        start5 = 1'b0; enter5 = 1'b0; ib_en5 = 1'b0; clear5 = 1'b0;
        start9 = 1'b0; enter9 = 1'b0; ib_en9 = 1'b0; clear9 = 1'b0;
    endtask

    task automatic setTurn(input int idx, input bit t);
        @(negedge clk);
        if (idx == 0) turn5 = t;
        else          turn9 = t;
        model_turn[idx] = t;
    endtask

    task automatic doStart(input int idx);
        armed[idx] = 1'b1;
        applyStimulus(idx, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 7'd0);
        idle(2);
    endtask

    task automatic doLocal(input int idx, input logic [7:0] bcd);
        modelLocal(idx, bcd);
        applyStimulus(idx, 1'b0, 1'b1, 1'b0, 1'b0, bcd, 3'd0, 7'd0);
        idle(3);
    endtask

    task automatic doRemote(input int idx, input logic [2:0] mtype, input int n);
        modelRemote(idx, mtype, n);
        applyStimulus(idx, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, mtype, 7'(n));
        idle(3);
    endtask

    task automatic doClear(input int idx, input bit with_entry, input logic [7:0] bcd);
        m_circle[idx] = '0;
        applyStimulus(idx, 1'b0, with_entry, 1'b0, 1'b1, bcd, 3'd0, 7'd0);
        idle(3);
    endtask

    task automatic markPos(input int idx, input int p);
        if (m_circle[idx][p]) return;
        doStart(idx);
        doLocal(idx, toBcd(num_of[idx][p]));
    endtask

    task automatic randomOps(input int idx, input int n);
        int cells = side_of[idx] * side_of[idx];
        for (int it = 0; it < n; it++) begin
            int r = $urandom_range(0, 11);
            if (r == 0) begin
                doClear(idx, 1'b0, 8'h00);
            end else if (r == 1) begin
                setTurn(idx, 1'($urandom_range(0, 1)));
            end else if (r <= 3) begin
                doStart(idx);
            end else if (r <= 7) begin
                if ($urandom_range(0, 3) != 0) doLocal(idx, toBcd($urandom_range(1, cells)));
                else                           doLocal(idx, 8'($urandom));
            end else begin
                int          pick = $urandom_range(0, 3);
                logic [2:0]  mt   = (pick <= 1) ? SEL_NUM : ((pick == 2) ? STATE_WIN : 3'd2);
                int          num  = (idx == 0) ? $urandom_range(0, 31) : $urandom_range(0, 127);
                if ($urandom_range(0, 2) != 0) num = $urandom_range(1, cells);
                doRemote(idx, mt, num);
            end
        end
    endtask

    initial begin
        int perm[81];
        rst = 1'b1; ib_rst = 1'b0;
        start5 = 0; turn5 = 0; enter5 = 0; ib_en5 = 0; clear5 = 0;
        bcd5 = '0; type5 = '0; ib_num5 = '0;
        start9 = 0; turn9 = 0; enter9 = 0; ib_en9 = 0; clear9 = 0;
        bcd9 = '0; type9 = '0; ib_num9 = '0;
        model_turn[0] = 1'b0;
        model_turn[1] = 1'b0;
        resetModel();

        // SIDE=5: identity map (13 -> 12); SIDE=9: shuffled map
        for (int i = 0; i < 81; i++) perm[i] = i;
        for (int i = 80; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int k = 1; k <= 25; k++) begin
            pos_map[0][k] = k - 1;
            num_of[0][k - 1] = k;
            map5[(k-1)*5 +: 5] = 5'(k - 1);
        end
        for (int k = 1; k <= 81; k++) begin
            pos_map[1][k] = perm[k - 1];
            num_of[1][perm[k - 1]] = k;
            map9[(k-1)*7 +: 7] = 7'(perm[k - 1]);
        end

        idle(2);
        rst = 1'b0;
        idle(1);
        checkOutput("reset circle5", 81'(circle5), 81'd0);
        checkOutput("reset circle9", circle9, 81'd0);
        checkOutput("reset line_count5", 81'(lc5), 81'd0);
        checkOutput("reset bingo5", 81'(bingo5), 81'd0);
        checkOutput("reset guess_number9", 81'(gnum9), 81'd0);
        checkOutput("reset pulses", 81'({done5, reject5, done9, reject9}), 81'd0);

        // Local accept, then an entry with no round armed
        setTurn(0, 1'b1);
        doStart(0);
        doLocal(0, 8'h13);
        doLocal(0, 8'h14);

        // Local rejects: out of range, zero, duplicate, bad digit
        doStart(0);
        doLocal(0, 8'h26);
        doLocal(0, 8'h00);
        doLocal(0, 8'h13);
        doLocal(0, 8'h1A);

        // Remote: accept 7 (round still armed), idempotent 7, out of range 30
        setTurn(0, 1'b0);
        doRemote(0, SEL_NUM, 7);
        doStart(0);
        doRemote(0, SEL_NUM, 7);
        doStart(0);
        doRemote(0, SEL_NUM, 30);
        doLocal(0, 8'h05);
        doRemote(0, STATE_WIN, 0);
        doRemote(0, SEL_NUM, 5);

        // Row 0 and main diagonal
        setTurn(0, 1'b1);
        for (int p = 0; p < 5; p++) markPos(0, p);
        for (int i = 0; i < 5; i++) markPos(0, i * 6);

        // clear_guess together with a valid entry; round stays armed
        doStart(0);
        doClear(0, 1'b1, 8'h04);
        checkOutput("clear circle5", 81'(circle5), 81'd0);
        checkOutput("clear line_count5", 81'(lc5), 81'd0);
        doLocal(0, 8'h04);

        // Async reset while guess_done is high
        doStart(0);
        modelLocal(0, 8'h09);
        @(negedge clk);
        enter5 = 1'b1; bcd5 = 8'h09;
        @(posedge clk);
        #1;
        enter5 = 1'b0;
        checkOutput("fin guess_done5", 81'(done5), 81'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst guess_done5", 81'(done5), 81'd0);
        checkOutput("async rst circle5", 81'(circle5), 81'd0);
        sbq0.delete();
        @(negedge clk);
        rst = 1'b0;
        resetModel();

        randomOps(0, 80);
        idle(4);

        // SIDE=9: BCD 81, range rejects, row 0 and diagonal
        setTurn(1, 1'b1);
        doStart(1);
        doLocal(1, 8'h81);
        doStart(1);
        doLocal(1, 8'h82);
        doLocal(1, 8'h90);
        doLocal(1, toBcd(num_of[1][0]));
        for (int p = 0; p < 9; p++) markPos(1, p);
        for (int i = 0; i < 9; i++) markPos(1, i * 10);
        randomOps(1, 50);

        // interboard_rst behaves like reset
        @(negedge clk);
        ib_rst = 1'b1;
        @(negedge clk);
        ib_rst = 1'b0;
        resetModel();
        checkOutput("ib_rst circle9", circle9, 81'd0);
        checkOutput("ib_rst guess_number9", 81'(gnum9), 81'd0);

        idle(5);
        checkOutput("scoreboard drained", 81'(sbq0.size() + sbq1.size()), 81'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
